// File: rtl/pcie_us_pkg.sv
// Shared types, constants and helpers for the UltraScale PCIe register completer.
package pcie_us_pkg;

  // CQ request types
  localparam logic [3:0] REQ_MEM_RD  = 4'b0000;
  localparam logic [3:0] REQ_MEM_WR  = 4'b0001;
  localparam logic [3:0] REQ_IO_RD   = 4'b0010;
  localparam logic [3:0] REQ_IO_WR   = 4'b0011;
  localparam logic [3:0] REQ_CFG_RD0 = 4'b1000;
  localparam logic [3:0] REQ_CFG_WR0 = 4'b1001;
  localparam logic [3:0] REQ_CFG_RD1 = 4'b1010;
  localparam logic [3:0] REQ_CFG_WR1 = 4'b1011;

  // Completion status
  localparam logic [2:0] CPL_SC = 3'b000;
  localparam logic [2:0] CPL_UR = 3'b001;
  localparam logic [2:0] CPL_CA = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DESC1,
    ST_WDATA,
    ST_DROP,
    ST_CPL0,
    ST_CPL1
  } state_t;

  typedef struct packed {
    logic [12:0] byte_count;
    logic [6:0]  lower_addr;
  } cpl_len_t;

  function automatic logic is_non_posted(input logic [3:0] req_type);
    return (req_type inside {REQ_MEM_RD, REQ_IO_RD, REQ_IO_WR,
                             REQ_CFG_RD0, REQ_CFG_WR0, REQ_CFG_RD1, REQ_CFG_WR1});
  endfunction

  // Single-DW completion length and starting byte address from first_be.
  function automatic cpl_len_t calc_cpl_len(input logic [3:0] first_be, input logic [4:0] addr_dw);
    cpl_len_t   r;
    logic [1:0] offs;
    casez (first_be)
      4'b1??1:                   r.byte_count = 13'd4;
      4'b01?1, 4'b1?10:          r.byte_count = 13'd3;
      4'b0011, 4'b0110, 4'b1100: r.byte_count = 13'd2;
      default:                   r.byte_count = 13'd1;
    endcase
    if (first_be[0])      offs = 2'd0;
    else if (first_be[1]) offs = 2'd1;
    else if (first_be[2]) offs = 2'd2;
    else if (first_be[3]) offs = 2'd3;
    else                  offs = 2'd0;
    r.lower_addr = {addr_dw, offs};
    return r;
  endfunction

endpackage

// File: rtl/pcie_us_reg_completer_if.sv
// CQ (request in) and CC (completion out) AXI-Stream bundle of the UltraScale PCIe core.
interface pcie_us_reg_completer_if #(
  parameter int DATA_WIDTH    = 64,
  parameter int KEEP_WIDTH    = DATA_WIDTH/32,
  parameter int CQ_USER_WIDTH = 85,
  parameter int CC_USER_WIDTH = 33
);
  logic [DATA_WIDTH-1:0]    s_axis_cq_tdata;
  logic [KEEP_WIDTH-1:0]    s_axis_cq_tkeep;
  logic                     s_axis_cq_tlast;
  logic                     s_axis_cq_tready;
  logic [CQ_USER_WIDTH-1:0] s_axis_cq_tuser;
  logic                     s_axis_cq_tvalid;

  logic [DATA_WIDTH-1:0]    m_axis_cc_tdata;
  logic [KEEP_WIDTH-1:0]    m_axis_cc_tkeep;
  logic                     m_axis_cc_tlast;
  logic                     m_axis_cc_tready;
  logic [CC_USER_WIDTH-1:0] m_axis_cc_tuser;
  logic                     m_axis_cc_tvalid;

  modport master (
    output s_axis_cq_tdata, s_axis_cq_tkeep, s_axis_cq_tlast, s_axis_cq_tuser, s_axis_cq_tvalid,
    input  s_axis_cq_tready,
    input  m_axis_cc_tdata, m_axis_cc_tkeep, m_axis_cc_tlast, m_axis_cc_tuser, m_axis_cc_tvalid,
    output m_axis_cc_tready
  );

  modport slave (
    input  s_axis_cq_tdata, s_axis_cq_tkeep, s_axis_cq_tlast, s_axis_cq_tuser, s_axis_cq_tvalid,
    output s_axis_cq_tready,
    output m_axis_cc_tdata, m_axis_cc_tkeep, m_axis_cc_tlast, m_axis_cc_tuser, m_axis_cc_tvalid,
    input  m_axis_cc_tready
  );
endinterface

// File: rtl/pcie_us_cc_cpl_fmt.sv
// Packs completion fields into the two 64-bit CC beats (descriptor DW0-1, DW2 + payload).
module pcie_us_cc_cpl_fmt (
  input  logic [6:0]  lower_addr,
  input  logic [12:0] byte_count,
  input  logic [10:0] dword_count,
  input  logic [2:0]  status,
  input  logic [15:0] requester_id,
  input  logic [7:0]  tag,
  input  logic [2:0]  tc,
  input  logic [2:0]  attr,
  input  logic [31:0] data,
  output logic [63:0] beat0,
  output logic [63:0] beat1
);
  always_comb begin
    beat0 = '0;
    beat1 = '0;
    beat0[6:0]   = lower_addr;
    beat0[28:16] = byte_count;
    beat0[42:32] = dword_count;
    beat0[45:43] = status;
    beat0[63:48] = requester_id;
    // completer_id [23:8], completer_id_en [24] and force_ecrc [31] stay zero
    beat1[7:0]   = tag;
    beat1[27:25] = tc;
    beat1[30:28] = attr;
    beat1[63:32] = data;
  end
endmodule

// File: rtl/pcie_us_reg_completer.sv
// Single-DW memory register completer on the UltraScale CQ/CC interfaces.
// Optional counters enabled by PCIE_US_REG_COMPLETER_STATS_EN.
module pcie_us_reg_completer
  import pcie_us_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int KEEP_WIDTH     = DATA_WIDTH/32,
  parameter int CQ_USER_WIDTH  = 85,
  parameter int CC_USER_WIDTH  = 33,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int BAR_ID         = 0
) (
  input  logic                      user_clk,
  input  logic                      user_reset_n,
  pcie_us_reg_completer_if.slave    bus,
  output logic                      pcie_cq_np_req,
  output logic                      reg_wr_valid,
  output logic [REG_ADDR_WIDTH-1:0] reg_wr_addr,
  output logic [31:0]               reg_wr_data,
  input  logic [REG_ADDR_WIDTH-1:0] reg_rd_addr,
  output logic [31:0]               reg_rd_data
`ifdef PCIE_US_REG_COMPLETER_STATS_EN
  ,
  output logic [15:0]               stat_rd_count,
  output logic [15:0]               stat_wr_count,
  output logic [15:0]               stat_ur_count
`endif
);
  localparam int REG_COUNT = 2**REG_ADDR_WIDTH;

  generate
    if (DATA_WIDTH != 64 || KEEP_WIDTH != 2 || CQ_USER_WIDTH < 4 || CC_USER_WIDTH < 1) begin : g_bad_cfg
      $error("pcie_us_reg_completer supports only a 64-bit datapath");
    end
  endgenerate

  state_t                    state_reg, state_next;
  logic                      ready_en_reg;
  logic [REG_ADDR_WIDTH-1:0] addr_idx_reg;
  logic [4:0]                addr_dw_reg;
  logic [3:0]                first_be_reg;
  logic [15:0]               req_id_reg;
  logic [7:0]                tag_reg;
  logic [2:0]                tc_reg, attr_reg;
  logic                      ur_reg, ur_next;
  logic [31:0]               cpl_data_reg;
  logic [31:0]               regfile [REG_COUNT];
  logic                      wr_valid_reg;
  logic [REG_ADDR_WIDTH-1:0] wr_addr_reg;
  logic [31:0]               wr_data_reg;

  logic        cq_hs, cc_hs, cc_valid, wr_en, desc_hit;
  logic [3:0]  desc_type;
  logic [31:0] wr_old, wr_merged;
  cpl_len_t    len;
  logic [63:0] beat0, beat1;

  assign cq_hs     = bus.s_axis_cq_tvalid && bus.s_axis_cq_tready;
  assign cc_valid  = (state_reg == ST_CPL0) || (state_reg == ST_CPL1);
  assign cc_hs     = cc_valid && bus.m_axis_cc_tready;
  assign desc_type = bus.s_axis_cq_tdata[14:11];
  assign desc_hit  = (bus.s_axis_cq_tdata[50:48] == 3'(BAR_ID)) && (bus.s_axis_cq_tdata[10:0] == 11'd1);

  always_comb begin
    state_next = state_reg;
    ur_next    = ur_reg;
    wr_en      = 1'b0;
    case (state_reg)
      ST_IDLE: if (cq_hs) begin
        ur_next    = 1'b0;
        state_next = bus.s_axis_cq_tlast ? ST_IDLE : ST_DESC1;
      end
      ST_DESC1: if (cq_hs) begin
        if (desc_hit && desc_type == REQ_MEM_RD) begin
          state_next = ST_CPL0;
        end else if (desc_hit && desc_type == REQ_MEM_WR) begin
          state_next = ST_WDATA;
        end else if (is_non_posted(desc_type)) begin
          ur_next    = 1'b1;
          state_next = bus.s_axis_cq_tlast ? ST_CPL0 : ST_DROP;
        end else begin
          state_next = bus.s_axis_cq_tlast ? ST_IDLE : ST_DROP;
        end
      end
      ST_WDATA: if (cq_hs) begin
        wr_en      = 1'b1;
        state_next = bus.s_axis_cq_tlast ? ST_IDLE : ST_DROP;
      end
      ST_DROP: if (cq_hs && bus.s_axis_cq_tlast) begin
        state_next = ur_reg ? ST_CPL0 : ST_IDLE;
      end
      ST_CPL0: if (cc_hs) state_next = ST_CPL1;
      ST_CPL1: if (cc_hs) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      state_reg    <= ST_IDLE;
      ready_en_reg <= 1'b0;
      ur_reg       <= 1'b0;
      addr_idx_reg <= '0;
      addr_dw_reg  <= '0;
      first_be_reg <= '0;
      req_id_reg   <= '0;
      tag_reg      <= '0;
      tc_reg       <= '0;
      attr_reg     <= '0;
      cpl_data_reg <= '0;
    end else begin
      state_reg    <= state_next;
      ready_en_reg <= 1'b1;
      ur_reg       <= ur_next;
      if (state_reg == ST_IDLE && cq_hs) begin
        addr_idx_reg <= bus.s_axis_cq_tdata[REG_ADDR_WIDTH+1:2];
        addr_dw_reg  <= bus.s_axis_cq_tdata[6:2];
        first_be_reg <= bus.s_axis_cq_tuser[3:0];
      end
      if (state_reg == ST_DESC1 && cq_hs) begin
        req_id_reg <= bus.s_axis_cq_tdata[31:16];
        tag_reg    <= bus.s_axis_cq_tdata[39:32];
        tc_reg     <= bus.s_axis_cq_tdata[59:57];
        attr_reg   <= bus.s_axis_cq_tdata[62:60];
      end
      // Snapshot read data on CPL0 entry so the completion payload is frozen
      if (state_next == ST_CPL0 && state_reg != ST_CPL0)
        cpl_data_reg <= ur_next ? 32'h0 : regfile[addr_idx_reg];
    end
  end

  assign wr_old = regfile[addr_idx_reg];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte_merge
      assign wr_merged[gi*8 +: 8] = first_be_reg[gi] ? bus.s_axis_cq_tdata[gi*8 +: 8] : wr_old[gi*8 +: 8];
    end
  endgenerate

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      for (int i = 0; i < REG_COUNT; i++) regfile[i] <= '0;
      wr_valid_reg <= 1'b0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
    end else begin
      wr_valid_reg <= wr_en;
      if (wr_en) begin
        regfile[addr_idx_reg] <= wr_merged;
        wr_addr_reg           <= addr_idx_reg;
        wr_data_reg           <= wr_merged;
      end
    end
  end

  assign reg_wr_valid = wr_valid_reg;
  assign reg_wr_addr  = wr_addr_reg;
  assign reg_wr_data  = wr_data_reg;
  assign reg_rd_data  = regfile[reg_rd_addr];

  assign len = calc_cpl_len(first_be_reg, addr_dw_reg);

  pcie_us_cc_cpl_fmt u_fmt (
    .lower_addr   (ur_reg ? 7'd0 : len.lower_addr),
    .byte_count   (ur_reg ? 13'd4 : len.byte_count),
    .dword_count  (ur_reg ? 11'd0 : 11'd1),
    .status       (ur_reg ? CPL_UR : CPL_SC),
    .requester_id (req_id_reg),
    .tag          (tag_reg),
    .tc           (tc_reg),
    .attr         (attr_reg),
    .data         (cpl_data_reg),
    .beat0        (beat0),
    .beat1        (beat1)
  );

  always_comb begin
    bus.m_axis_cc_tdata  = '0;
    bus.m_axis_cc_tkeep  = '0;
    bus.m_axis_cc_tlast  = 1'b0;
    bus.m_axis_cc_tvalid = cc_valid;
    bus.m_axis_cc_tuser  = '0;
    if (state_reg == ST_CPL0) begin
      bus.m_axis_cc_tdata = beat0;
      bus.m_axis_cc_tkeep = 2'b11;
    end else if (state_reg == ST_CPL1) begin
      bus.m_axis_cc_tdata = beat1;
      bus.m_axis_cc_tkeep = ur_reg ? 2'b01 : 2'b11;
      bus.m_axis_cc_tlast = 1'b1;
    end
  end

  assign bus.s_axis_cq_tready = ready_en_reg && (state_reg inside {ST_IDLE, ST_DESC1, ST_WDATA, ST_DROP});
  assign pcie_cq_np_req       = (state_reg == ST_IDLE);

`ifdef PCIE_US_REG_COMPLETER_STATS_EN
  logic [15:0] rd_cnt_reg, wr_cnt_reg, ur_cnt_reg;
  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      rd_cnt_reg <= '0;
      wr_cnt_reg <= '0;
      ur_cnt_reg <= '0;
    end else begin
      if (state_reg == ST_CPL1 && cc_hs && !ur_reg && rd_cnt_reg != 16'hFFFF) rd_cnt_reg <= rd_cnt_reg + 16'd1;
      if (state_reg == ST_CPL1 && cc_hs &&  ur_reg && ur_cnt_reg != 16'hFFFF) ur_cnt_reg <= ur_cnt_reg + 16'd1;
      if (wr_en && wr_cnt_reg != 16'hFFFF) wr_cnt_reg <= wr_cnt_reg + 16'd1;
    end
  end
  assign stat_rd_count = rd_cnt_reg;
  assign stat_wr_count = wr_cnt_reg;
  assign stat_ur_count = ur_cnt_reg;
`endif

endmodule

// File: tb/tb_pcie_us_reg_completer.sv
// Directed, table-driven bench for pcie_us_reg_completer plus backpressure and reset-abort sequences.
module tb_pcie_us_reg_completer;

  localparam logic [3:0]  T_MRD = 4'b0000, T_MWR = 4'b0001, T_IORD = 4'b0010;
  localparam logic [3:0]  T_CFGRD = 4'b1000, T_MSG = 4'b1100;
  localparam logic [15:0] RID  = 16'hBEEF;
  localparam logic [2:0]  TC   = 3'd2;
  localparam logic [2:0]  ATTR = 3'd5;
  localparam int          WAIT_LIMIT = 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        np_req, wr_valid;
  logic [3:0]  wr_addr, rd_addr;
  logic [31:0] wr_data, rd_data;
`ifdef PCIE_US_REG_COMPLETER_STATS_EN
  logic [15:0] st_rd, st_wr, st_ur;
`endif

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int cc_cnt = 0;
  logic [3:0]  last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;

  always #5 clk = ~clk;

  pcie_us_reg_completer_if #(.DATA_WIDTH(64), .KEEP_WIDTH(2), .CQ_USER_WIDTH(85), .CC_USER_WIDTH(33)) cq_cc ();

  pcie_us_reg_completer #(
    .DATA_WIDTH(64), .KEEP_WIDTH(2), .CQ_USER_WIDTH(85), .CC_USER_WIDTH(33),
    .REG_ADDR_WIDTH(4), .BAR_ID(0)
  ) dut (
    .user_clk       (clk),
    .user_reset_n   (rst_n),
    .bus            (cq_cc),
    .pcie_cq_np_req (np_req),
    .reg_wr_valid   (wr_valid),
    .reg_wr_addr    (wr_addr),
    .reg_wr_data    (wr_data),
    .reg_rd_addr    (rd_addr),
    .reg_rd_data    (rd_data)
`ifdef PCIE_US_REG_COMPLETER_STATS_EN
    ,
    .stat_rd_count  (st_rd),
    .stat_wr_count  (st_wr),
    .stat_ur_count  (st_ur)
`endif
  );

  always @(negedge clk) begin
    if (wr_valid === 1'b1) begin
      wr_cnt++;
      last_wr_addr = wr_addr;
      last_wr_data = wr_data;
    end
    if (cq_cc.m_axis_cc_tvalid === 1'b1 && cq_cc.m_axis_cc_tready === 1'b1) cc_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mk_b0(input logic [2:0] st, input logic [10:0] dwc,
                                        input logic [12:0] bc, input logic [6:0] la);
    logic [63:0] b = '0;
    b[6:0] = la; b[28:16] = bc; b[42:32] = dwc; b[45:43] = st; b[63:48] = RID;
    return b;
  endfunction

  function automatic logic [63:0] mk_b1(input logic [7:0] tag, input logic [31:0] data);
    logic [63:0] b = '0;
    b[7:0] = tag; b[27:25] = TC; b[30:28] = ATTR; b[63:32] = data;
    return b;
  endfunction

  // Called at a negedge; returns at the negedge following the beat handshake.
  task automatic cq_send(input logic [63:0] d, input logic [1:0] k, input logic last, input logic [3:0] be);
    int n = 0;
    cq_cc.s_axis_cq_tdata  = d;
    cq_cc.s_axis_cq_tkeep  = k;
    cq_cc.s_axis_cq_tlast  = last;
    cq_cc.s_axis_cq_tuser  = '0;
    cq_cc.s_axis_cq_tuser[3:0] = be;
    cq_cc.s_axis_cq_tvalid = 1'b1;
    while (cq_cc.s_axis_cq_tready !== 1'b1 && n < WAIT_LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (n >= WAIT_LIMIT) begin
      checks++;
      errors++;
      $display("FAIL cq_tready_wait: got 0 expected 1 within %0d cycles", WAIT_LIMIT);
    end
    @(negedge clk);
    cq_cc.s_axis_cq_tvalid = 1'b0;
    cq_cc.s_axis_cq_tlast  = 1'b0;
  endtask

  task automatic send_req(input logic [3:0] rtype, input logic [63:0] addr, input logic [3:0] be,
                          input logic [7:0] tag, input logic [2:0] bar, input logic [10:0] dwc,
                          input int ndata, input logic [63:0] wdata);
    logic [63:0] desc = '0;
    desc[10:0]  = dwc;
    desc[14:11] = rtype;
    desc[31:16] = RID;
    desc[39:32] = tag;
    desc[50:48] = bar;
    desc[59:57] = TC;
    desc[62:60] = ATTR;
    cq_send({addr[63:2], 2'b00}, 2'b11, 1'b0, be);
    cq_send(desc, 2'b11, ndata == 0, be);
    if (ndata == 1) cq_send({32'h0, wdata[31:0]}, 2'b01, 1'b1, be);
    if (ndata == 2) cq_send(wdata, 2'b11, 1'b1, be);
  endtask

  task automatic wait_cc_hs(output logic ok);
    int n = 0;
    while (!(cq_cc.m_axis_cc_tvalid === 1'b1 && cq_cc.m_axis_cc_tready === 1'b1) && n < WAIT_LIMIT) begin
      @(negedge clk);
      n++;
    end
    ok = (n < WAIT_LIMIT);
  endtask

  task automatic get_cpl(output logic ok, output logic [63:0] b0, output logic [1:0] k0, output logic l0,
                         output logic [63:0] b1, output logic [1:0] k1, output logic l1);
    logic ok0, ok1;
    wait_cc_hs(ok0);
    b0 = cq_cc.m_axis_cc_tdata; k0 = cq_cc.m_axis_cc_tkeep; l0 = cq_cc.m_axis_cc_tlast;
    @(negedge clk);
    wait_cc_hs(ok1);
    b1 = cq_cc.m_axis_cc_tdata; k1 = cq_cc.m_axis_cc_tkeep; l1 = cq_cc.m_axis_cc_tlast;
    @(negedge clk);
    ok = ok0 && ok1;
  endtask

  typedef struct {
    logic [3:0]  rtype;
    logic [63:0] addr;
    logic [3:0]  be;
    logic [7:0]  tag;
    logic [2:0]  bar;
    logic [10:0] dwc;
    int          ndata;
    logic [63:0] wdata;
    logic        exp_cpl;
    logic [2:0]  exp_st;
    logic [6:0]  exp_la;
    logic [12:0] exp_bc;
    logic [10:0] exp_dwc;
    logic [31:0] exp_data;
    logic        exp_wr;
    logic [3:0]  exp_wr_addr;
    logic [31:0] exp_wr_data;
    logic [3:0]  chk_idx;
    logic [31:0] exp_reg;
  } vec_t;

  vec_t vecs[15];

  initial begin
    logic        ok, l0, l1;
    logic [63:0] b0, b1, held;
    logic [1:0]  k0, k1;
    int          wr_before, cc_before;

    cq_cc.s_axis_cq_tdata  = '0;
    cq_cc.s_axis_cq_tkeep  = '0;
    cq_cc.s_axis_cq_tlast  = 1'b0;
    cq_cc.s_axis_cq_tuser  = '0;
    cq_cc.s_axis_cq_tvalid = 1'b0;
    cq_cc.m_axis_cc_tready = 1'b1;
    rd_addr = 4'd3;

    //           type     addr            be    tag    bar  dwc ndata wdata                  cpl st  la     bc  dwc data           wr a  wr_data        idx  reg
    vecs[0]  = '{T_MWR,   64'h0C,         4'hF, 8'h00, 3'd0, 1, 1, 64'h12345678,          0, 0, 7'h00, 0, 0, 32'h0,          1, 3, 32'h12345678, 3,  32'h12345678};
    vecs[1]  = '{T_MRD,   64'h0C,         4'hF, 8'h11, 3'd0, 1, 0, 64'h0,                 1, 0, 7'h0C, 4, 1, 32'h12345678,   0, 0, 32'h0,        3,  32'h12345678};
    vecs[2]  = '{T_MWR,   64'h0C,         4'h2, 8'h00, 3'd0, 1, 1, 64'hAABBCCDD,          0, 0, 7'h00, 0, 0, 32'h0,          1, 3, 32'h1234CC78, 3,  32'h1234CC78};
    vecs[3]  = '{T_MRD,   64'h0C,         4'h2, 8'h22, 3'd0, 1, 0, 64'h0,                 1, 0, 7'h0D, 1, 1, 32'h1234CC78,   0, 0, 32'h0,        3,  32'h1234CC78};
    vecs[4]  = '{T_IORD,  64'h0C,         4'hF, 8'h5A, 3'd0, 1, 0, 64'h0,                 1, 1, 7'h00, 4, 0, 32'h0,          0, 0, 32'h0,        3,  32'h1234CC78};
    vecs[5]  = '{T_MWR,   64'h04,         4'hF, 8'h00, 3'd0, 1, 1, 64'hCAFEF00D,          0, 0, 7'h00, 0, 0, 32'h0,          1, 1, 32'hCAFEF00D, 1,  32'hCAFEF00D};
    vecs[6]  = '{T_MWR,   64'h04,         4'hF, 8'h00, 3'd0, 2, 2, 64'h22222222_11111111, 0, 0, 7'h00, 0, 0, 32'h0,          0, 0, 32'h0,        1,  32'hCAFEF00D};
    vecs[7]  = '{T_MRD,   64'h04,         4'hF, 8'h33, 3'd1, 1, 0, 64'h0,                 1, 1, 7'h00, 4, 0, 32'h0,          0, 0, 32'h0,        1,  32'hCAFEF00D};
    vecs[8]  = '{T_MWR,   64'h04,         4'hF, 8'h00, 3'd1, 1, 1, 64'h0,                 0, 0, 7'h00, 0, 0, 32'h0,          0, 0, 32'h0,        1,  32'hCAFEF00D};
    vecs[9]  = '{T_MRD,   64'h3C,         4'hC, 8'h44, 3'd0, 1, 0, 64'h0,                 1, 0, 7'h3E, 2, 1, 32'h0,          0, 0, 32'h0,        15, 32'h0};
    vecs[10] = '{T_MWR,   64'h1_0000_0008, 4'h9, 8'h00, 3'd0, 1, 1, 64'hA1B2C3D4,         0, 0, 7'h00, 0, 0, 32'h0,          1, 2, 32'hA10000D4, 2,  32'hA10000D4};
    vecs[11] = '{T_MRD,   64'h48,         4'h9, 8'h55, 3'd0, 1, 0, 64'h0,                 1, 0, 7'h48, 4, 1, 32'hA10000D4,   0, 0, 32'h0,        2,  32'hA10000D4};
    vecs[12] = '{T_MSG,   64'h0C,         4'hF, 8'h00, 3'd0, 1, 0, 64'h0,                 0, 0, 7'h00, 0, 0, 32'h0,          0, 0, 32'h0,        3,  32'h1234CC78};
    vecs[13] = '{T_CFGRD, 64'h00,         4'hF, 8'h77, 3'd0, 1, 0, 64'h0,                 1, 1, 7'h00, 4, 0, 32'h0,          0, 0, 32'h0,        3,  32'h1234CC78};
    vecs[14] = '{T_MRD,   64'h0C,         4'hF, 8'h66, 3'd0, 2, 0, 64'h0,                 1, 1, 7'h00, 4, 0, 32'h0,          0, 0, 32'h0,        3,  32'h1234CC78};

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cq_tready", cq_cc.s_axis_cq_tready, 0);
    chk("rst_cc_tvalid", cq_cc.m_axis_cc_tvalid, 0);
    chk("rst_cc_tdata", cq_cc.m_axis_cc_tdata, 0);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_reg3", rd_data, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_cq_tready", cq_cc.s_axis_cq_tready, 1);
    chk("post_rst_np_req", np_req, 1);

    for (int i = 0; i < 15; i++) begin
      wr_before = wr_cnt;
      cc_before = cc_cnt;
      send_req(vecs[i].rtype, vecs[i].addr, vecs[i].be, vecs[i].tag, vecs[i].bar,
               vecs[i].dwc, vecs[i].ndata, vecs[i].wdata);
      if (vecs[i].exp_cpl) begin
        get_cpl(ok, b0, k0, l0, b1, k1, l1);
        chk($sformatf("v%0d_cpl_seen", i), ok, 1);
        chk($sformatf("v%0d_cpl0", i), b0, mk_b0(vecs[i].exp_st, vecs[i].exp_dwc, vecs[i].exp_bc, vecs[i].exp_la));
        chk($sformatf("v%0d_cpl0_keep", i), k0, 2'b11);
        chk($sformatf("v%0d_cpl0_last", i), l0, 0);
        chk($sformatf("v%0d_cpl1", i), b1, mk_b1(vecs[i].tag, vecs[i].exp_data));
        chk($sformatf("v%0d_cpl1_keep", i), k1, (vecs[i].exp_st == 3'd1) ? 2'b01 : 2'b11);
        chk($sformatf("v%0d_cpl1_last", i), l1, 1);
      end
      repeat (6) @(negedge clk);
      chk($sformatf("v%0d_cc_beats", i), cc_cnt - cc_before, vecs[i].exp_cpl ? 2 : 0);
      chk($sformatf("v%0d_wr_pulses", i), wr_cnt - wr_before, vecs[i].exp_wr ? 1 : 0);
      if (vecs[i].exp_wr) begin
        chk($sformatf("v%0d_wr_addr", i), last_wr_addr, vecs[i].exp_wr_addr);
        chk($sformatf("v%0d_wr_data", i), last_wr_data, vecs[i].exp_wr_data);
      end
      rd_addr = vecs[i].chk_idx;
      #1;
      chk($sformatf("v%0d_reg", i), rd_data, vecs[i].exp_reg);
      $display("vec %0d type=%b addr=0x%0h be=%b tag=0x%0h done (checks=%0d)",
               i, vecs[i].rtype, vecs[i].addr, vecs[i].be, vecs[i].tag, checks);
    end

    // CC backpressure: CPL0 must hold and the CQ side must stall
    cq_cc.m_axis_cc_tready = 1'b0;
    send_req(T_MRD, 64'h0C, 4'hF, 8'h99, 3'd0, 1, 0, 64'h0);
    held = mk_b0(3'd0, 11'd1, 13'd4, 7'h0C);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d_tvalid", k), cq_cc.m_axis_cc_tvalid, 1);
      chk($sformatf("bp%0d_tdata", k), cq_cc.m_axis_cc_tdata, held);
      chk($sformatf("bp%0d_cq_tready", k), cq_cc.s_axis_cq_tready, 0);
      chk($sformatf("bp%0d_np_req", k), np_req, 0);
      @(negedge clk);
    end
    cq_cc.m_axis_cc_tready = 1'b1;
    get_cpl(ok, b0, k0, l0, b1, k1, l1);
    chk("bp_cpl_seen", ok, 1);
    chk("bp_cpl0", b0, held);
    chk("bp_cpl1", b1, mk_b1(8'h99, 32'h1234CC78));
    chk("bp_cpl1_last", l1, 1);
    $display("backpressure read tag=0x99 done (checks=%0d)", checks);

    // Asynchronous reset while CPL1 is on the bus
    repeat (2) @(negedge clk);
    cq_cc.m_axis_cc_tready = 1'b0;
    send_req(T_MRD, 64'h0C, 4'hF, 8'hA5, 3'd0, 1, 0, 64'h0);
    chk("ra_cpl0_tvalid", cq_cc.m_axis_cc_tvalid, 1);
    cq_cc.m_axis_cc_tready = 1'b1;
    @(negedge clk);
    cq_cc.m_axis_cc_tready = 1'b0;
    chk("ra_in_cpl1", cq_cc.m_axis_cc_tlast, 1);
    rd_addr = 4'd3;
    #2 rst_n = 1'b0;
    #1;
    chk("ra_tvalid_drop", cq_cc.m_axis_cc_tvalid, 0);
    chk("ra_reg3_clear", rd_data, 0);
    chk("ra_cq_tready", cq_cc.s_axis_cq_tready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cq_cc.m_axis_cc_tready = 1'b1;
    @(negedge clk);
    chk("ra_no_resume", cq_cc.m_axis_cc_tvalid, 0);
    send_req(T_MRD, 64'h0C, 4'hF, 8'hB6, 3'd0, 1, 0, 64'h0);
    get_cpl(ok, b0, k0, l0, b1, k1, l1);
    chk("ra_cpl_seen", ok, 1);
    chk("ra_cpl0", b0, mk_b0(3'd0, 11'd1, 13'd4, 7'h0C));
    chk("ra_cpl1", b1, mk_b1(8'hB6, 32'h0));
    $display("reset-abort then read tag=0xB6 done (checks=%0d)", checks);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
